// File: rtl/impl_word_feeder_if.sv
// Handshake bundle for impl_word_feeder: the serial bit input and the
// buffered word output with its frame tags and occupancy.
interface impl_word_feeder_if #(
  parameter int COUNT_OF_BITS = 4,
  parameter int FIFO_DEPTH    = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                     ser_valid;
  logic                     ser_bit;
  logic                     ser_last;
  logic                     ser_ready;
  logic [COUNT_OF_BITS-1:0] num;
  logic                     num_valid;
  logic                     num_ready;
  logic                     frame_start;
  logic                     frame_end;
  logic                     num_partial;
  logic [CW-1:0]            fifo_count;

  modport slave (
    input  ser_valid, ser_bit, ser_last, num_ready,
    output ser_ready, num, num_valid, frame_start, frame_end, num_partial, fifo_count
  );

  modport master (
    output ser_valid, ser_bit, ser_last, num_ready,
    input  ser_ready, num, num_valid, frame_start, frame_end, num_partial, fifo_count
  );
endinterface

// File: rtl/impl_word_feeder.sv
// Deserialises a framed LSB-first bit stream into words, tags frame start/end/partial
// and buffers them in a first-word-fall-through FIFO with valid/ready output.
module impl_word_feeder #(
  parameter int COUNT_OF_BITS = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  impl_word_feeder_if.slave bus
);
  localparam int IW = $clog2(COUNT_OF_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                     partial;
    logic                     last;
    logic                     start;
    logic [COUNT_OF_BITS-1:0] word;
  } entry_t;

  logic [COUNT_OF_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     start_pending_q, start_pending_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  entry_t                   mem_q [FIFO_DEPTH];
  entry_t                   mem_d [FIFO_DEPTH];

  logic                     ser_ready;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic [COUNT_OF_BITS-1:0] next_word;
  entry_t                   head;

  // Readiness looks only at the registered count, so a full FIFO refuses
  // a bit even when the head is being popped in the same cycle.
  assign ser_ready = (count_q != CW'(FIFO_DEPTH));

  always_comb begin
    shift_d         = shift_q;
    idx_d           = idx_q;
    start_pending_d = start_pending_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    mem_d           = mem_q;
    next_word       = shift_q;
    next_word[idx_q] = bus.ser_bit;

    accept = bus.ser_valid && ser_ready;
    push   = accept && ((idx_q == IW'(COUNT_OF_BITS - 1)) || bus.ser_last);
    pop    = (count_q != '0) && bus.num_ready;

    if (push) begin
      mem_d[wr_ptr_q] = '{partial: (idx_q != IW'(COUNT_OF_BITS - 1)),
                          last:    bus.ser_last,
                          start:   start_pending_q,
                          word:    next_word};
      wr_ptr_d        = wr_ptr_q + PW'(1);
      start_pending_d = bus.ser_last;
      shift_d         = '0;
      idx_d           = '0;
    end else if (accept) begin
      shift_d = next_word;
      idx_d   = idx_q + IW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q         <= '0;
      idx_q           <= '0;
      start_pending_q <= 1'b1;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      shift_q         <= shift_d;
      idx_q           <= idx_d;
      start_pending_q <= start_pending_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      mem_q           <= mem_d;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.ser_ready   = ser_ready;
  assign bus.num_valid   = (count_q != '0);
  assign bus.num         = bus.num_valid ? head.word : '0;
  assign bus.frame_start = bus.num_valid && head.start;
  assign bus.frame_end   = bus.num_valid && head.last;
  assign bus.num_partial = bus.num_valid && head.partial;
  assign bus.fifo_count  = count_q;
endmodule

// File: tb/tb_impl_word_feeder.sv
// Directed bench for impl_word_feeder (COUNT_OF_BITS=4, FIFO_DEPTH=4);
// head vector = {num_valid, frame_start, frame_end, num_partial, num}.
module tb_impl_word_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  impl_word_feeder_if #(.COUNT_OF_BITS(4), .FIFO_DEPTH(4)) bus ();

  impl_word_feeder #(.COUNT_OF_BITS(4), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] head();
    return {bus.num_valid, bus.frame_start, bus.frame_end, bus.num_partial, bus.num};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic l);
    bus.ser_valid = 1'b1;
    bus.ser_bit   = b;
    bus.ser_last  = l;
  endtask

  task automatic idle();
    bus.ser_valid = 1'b0;
    bus.ser_bit   = 1'b0;
    bus.ser_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    vectors++;
    if (head() !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_head got %h expected %h", head(), 8'h00);
    end
    vectors++;
    if (bus.fifo_count !== 3'd0 || bus.ser_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_count_ready got %0d/%b expected 0/1", bus.fifo_count, bus.ser_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_word();
    logic [3:0] bits;
    bits = 4'b1101;
    bus.num_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(bits[i], i == 3);
      tick();
    end
    idle();
    vectors++;
    if (head() !== 8'hED) begin
      miscompares++;
      $display("FAIL full_word got %h expected %h", head(), 8'hED);
    end
    tick();
    vectors++;
    if (head() !== 8'h00) begin
      miscompares++;
      $display("FAIL full_word_one_cycle got %h expected %h", head(), 8'h00);
    end
  endtask

  task automatic test_two_words();
    logic [7:0] bits;
    bits = 8'b0000_1111;
    bus.num_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(bits[i], i == 7);
      tick();
      if (i == 3) begin
        vectors++;
        if (head() !== 8'hCF) begin
          miscompares++;
          $display("FAIL two_words_first got %h expected %h", head(), 8'hCF);
        end
      end
    end
    idle();
    vectors++;
    if (head() !== 8'hA0) begin
      miscompares++;
      $display("FAIL two_words_second got %h expected %h", head(), 8'hA0);
    end
    tick();
  endtask

  task automatic test_partial();
    logic [3:0] bits;
    bits = 4'b1000;
    bus.num_ready = 1'b0;
    drive(1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1);
    tick();
    idle();
    vectors++;
    if (head() !== 8'hF3) begin
      miscompares++;
      $display("FAIL partial_word got %h expected %h", head(), 8'hF3);
    end
    for (int i = 0; i < 4; i++) begin
      drive(bits[i], i == 3);
      tick();
    end
    idle();
    vectors++;
    if (head() !== 8'hF3 || bus.fifo_count !== 3'd2) begin
      miscompares++;
      $display("FAIL partial_hold got %h/%0d expected %h/2", head(), bus.fifo_count, 8'hF3);
    end
    bus.num_ready = 1'b1;
    tick();
    vectors++;
    if (head() !== 8'hE8 || bus.fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL partial_next got %h/%0d expected %h/1", head(), bus.fifo_count, 8'hE8);
    end
    tick();
    vectors++;
    if (head() !== 8'h00) begin
      miscompares++;
      $display("FAIL partial_drain got %h expected %h", head(), 8'h00);
    end
  endtask

  task automatic test_full_fifo();
    logic [3:0] words [4];
    words = '{4'hA, 4'h5, 4'hC, 4'h3};
    bus.num_ready = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 4; i++) begin
        drive(words[w][i], 1'b0);
        tick();
      end
    end
    vectors++;
    if (bus.fifo_count !== 3'd4 || bus.ser_ready !== 1'b0 || head() !== 8'hCA) begin
      miscompares++;
      $display("FAIL fifo_full got %0d/%b/%h expected 4/0/%h", bus.fifo_count, bus.ser_ready, head(), 8'hCA);
    end
    drive(1'b1, 1'b1);
    tick();
    tick();
    vectors++;
    if (bus.fifo_count !== 3'd4 || head() !== 8'hCA) begin
      miscompares++;
      $display("FAIL fifo_hold got %0d/%h expected 4/%h", bus.fifo_count, head(), 8'hCA);
    end
    bus.num_ready = 1'b1;
    tick();
    vectors++;
    if (head() !== 8'h85 || bus.fifo_count !== 3'd3 || bus.ser_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fifo_pop1 got %h/%0d/%b expected %h/3/1", head(), bus.fifo_count, bus.ser_ready, 8'h85);
    end
    tick();
    idle();
    vectors++;
    if (head() !== 8'h8C || bus.fifo_count !== 3'd3) begin
      miscompares++;
      $display("FAIL fifo_pop2 got %h/%0d expected %h/3", head(), bus.fifo_count, 8'h8C);
    end
    tick();
    vectors++;
    if (head() !== 8'h83 || bus.fifo_count !== 3'd2) begin
      miscompares++;
      $display("FAIL fifo_pop3 got %h/%0d expected %h/2", head(), bus.fifo_count, 8'h83);
    end
    tick();
    vectors++;
    if (head() !== 8'hB1 || bus.fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL fifo_bit17 got %h/%0d expected %h/1", head(), bus.fifo_count, 8'hB1);
    end
    tick();
    vectors++;
    if (head() !== 8'h00 || bus.fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL fifo_empty got %h/%0d expected %h/0", head(), bus.fifo_count, 8'h00);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] bits;
    bits = 4'b1010;
    bus.num_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    idle();
    vectors++;
    if (head() !== 8'hCF) begin
      miscompares++;
      $display("FAIL areset_pre got %h expected %h", head(), 8'hCF);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (head() !== 8'h00 || bus.fifo_count !== 3'd0 || bus.ser_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_now got %h/%0d/%b expected 00/0/1", head(), bus.fifo_count, bus.ser_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.num_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(bits[i], i == 3);
      tick();
    end
    idle();
    vectors++;
    if (head() !== 8'hEA) begin
      miscompares++;
      $display("FAIL areset_after got %h expected %h", head(), 8'hEA);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] first;
    logic [3:0] v;
    first = 4'h6;
    bus.num_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(first[i], 1'b0);
      tick();
    end
    vectors++;
    if (head() !== 8'hC6 || bus.fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL b2b_prefill got %h/%0d expected %h/1", head(), bus.fifo_count, 8'hC6);
    end
    for (int k = 0; k < 10; k++) begin
      v = 4'((k * 7 + 3) % 16);
      for (int i = 0; i < 4; i++) begin
        bus.num_ready = (i == 3);
        drive(v[i], 1'b0);
        tick();
      end
      vectors++;
      if (head() !== {4'b1000, v} || bus.fifo_count !== 3'd1) begin
        miscompares++;
        $display("FAIL b2b_word%0d got %h/%0d expected %h/1", k, head(), bus.fifo_count, {4'b1000, v});
      end
    end
    idle();
    bus.num_ready = 1'b1;
    tick();
    vectors++;
    if (head() !== 8'h00 || bus.fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_drain got %h/%0d expected 00/0", head(), bus.fifo_count);
    end
  endtask

  initial begin
    bus.ser_valid = 1'b0;
    bus.ser_bit   = 1'b0;
    bus.ser_last  = 1'b0;
    bus.num_ready = 1'b0;
    test_reset();
    test_full_word();
    test_two_words();
    test_partial();
    test_full_fifo();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
